// File: rtl/sram_2prf_v2.sv
// sram_2prf_v2: single-clock 1W/1R register-file SRAM model.
// Per-bit write mask, write-first collision forwarding, optional output
// register, post-reset initialisation sweep and saturating collision counter.
module sram_2prf_v2 #(
  parameter int                  ADDR_WIDTH  = 10,
  parameter int                  DATA_WIDTH  = 8,
  parameter int                  ADDR_SPACE  = 1024,
  parameter int                  OUT_REG     = 0,
  parameter int                  INIT_ON_RST = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL  = {DATA_WIDTH{1'b0}},
  parameter int                  CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] din_w,
  input  logic [DATA_WIDTH-1:0] wmask_n,
  input  logic                  ce_w,
  input  logic                  en_w,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  input  logic                  ce_r,
  input  logic                  en_r,
  output logic [DATA_WIDTH-1:0] dout_r,
  output logic                  dout_vld,
  output logic                  init_busy,
  output logic [CNT_WIDTH-1:0]  coll_cnt
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One extra bit so ADDR_SPACE == 2**ADDR_WIDTH is representable.
  localparam int                  SPACE_W   = ADDR_WIDTH + 1;
  localparam logic [SPACE_W-1:0]  SPACE     = SPACE_W'(ADDR_SPACE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_SPACE - 1);
  localparam state_t              RST_STATE = (INIT_ON_RST != 0) ? ST_INIT : ST_RUN;
  localparam logic                RST_BUSY  = (INIT_ON_RST != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  // Bitwise merge: mask bit 0 takes the new bit, mask bit 1 keeps the old bit.
  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] new_d,
    input logic [DATA_WIDTH-1:0] old_d,
    input logic [DATA_WIDTH-1:0] mask_n
  );
    return (new_d & ~mask_n) | (old_d & mask_n);
  endfunction

  // True when an address falls inside the populated part of the array.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < SPACE);
  endfunction

  logic [DATA_WIDTH-1:0] mem [ADDR_SPACE];

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [ADDR_WIDTH-1:0]  init_cnt_r;
  logic [ADDR_WIDTH-1:0]  init_cnt_nxt_s;
  logic                   init_busy_r;

  logic                   wr_s;
  logic                   rd_s;
  logic                   w_in_s;
  logic                   r_in_s;
  logic                   coll_s;
  logic [DATA_WIDTH-1:0]  old_w_s;
  logic [DATA_WIDTH-1:0]  merged_s;
  logic [DATA_WIDTH-1:0]  rd_data_s;

  logic                   mem_we_s;
  logic [ADDR_WIDTH-1:0]  mem_wa_s;
  logic [DATA_WIDTH-1:0]  mem_wd_s;

  logic                   stage_vld_s;
  logic [DATA_WIDTH-1:0]  stage_data_s;
  logic [DATA_WIDTH-1:0]  dout_data_r;
  logic                   dout_vld_r;
  logic [CNT_WIDTH-1:0]   coll_cnt_r;

  // Port strobes, range checks, collision detect and write-first read data.
  always_comb begin
    wr_s     = (!ce_w) && (!en_w) && (state_r == ST_RUN);
    rd_s     = (!ce_r) && (!en_r) && (state_r == ST_RUN);
    w_in_s   = in_range(addr_w);
    r_in_s   = in_range(addr_r);
    coll_s   = wr_s && rd_s && w_in_s && r_in_s && (addr_w == addr_r);
    old_w_s  = mem[addr_w];
    merged_s = merge_word(din_w, old_w_s, wmask_n);
    if (!r_in_s) begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end else if (coll_s) begin
      rd_data_s = merged_s;
    end else begin
      rd_data_s = mem[addr_r];
    end
  end

  // Next-state logic: sweep one word per cycle, leave INIT on the last word.
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    case (state_r)
      ST_INIT: begin
        init_cnt_nxt_s = init_cnt_r + ADDR_WIDTH'(1);
        if (init_cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Array write port select: sweep during INIT, masked user write during RUN.
  // The array is left alone on a reset edge.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = addr_w;
    mem_wd_s = merged_s;
    if (state_r == ST_INIT) begin
      mem_we_s = !rst;
      mem_wa_s = init_cnt_r;
      mem_wd_s = INIT_VAL;
    end else begin
      mem_we_s = wr_s && w_in_s && !rst;
      mem_wa_s = addr_w;
      mem_wd_s = merged_s;
    end
  end

  // FSM state, sweep pointer and busy flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RST_STATE;
      init_cnt_r  <= {ADDR_WIDTH{1'b0}};
      init_busy_r <= RST_BUSY;
    end else begin
      state_r     <= state_nxt_s;
      init_cnt_r  <= init_cnt_nxt_s;
      init_busy_r <= (state_nxt_s == ST_INIT);
    end
  end

  // Storage array; no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_wa_s] <= mem_wd_s;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  pipe_vld_r;
      logic [DATA_WIDTH-1:0] pipe_data_r;

      // Extra read stage: capture read data on the accept edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_vld_r  <= 1'b0;
          pipe_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
          pipe_vld_r <= rd_s;
          if (rd_s) begin
            pipe_data_r <= rd_data_s;
          end
        end
      end

      assign stage_vld_s  = pipe_vld_r;
      assign stage_data_s = pipe_data_r;
    end else begin : g_no_out_reg
      assign stage_vld_s  = rd_s;
      assign stage_data_s = rd_data_s;
    end
  endgenerate

  // Output register: load only on a valid read so dout_r holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_data_r <= {DATA_WIDTH{1'b0}};
      dout_vld_r  <= 1'b0;
    end else begin
      dout_vld_r <= stage_vld_s;
      if (stage_vld_s) begin
        dout_data_r <= stage_data_s;
      end
    end
  end

  // Saturating count of same-address read/write cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (coll_s && (coll_cnt_r != CNT_MAX)) begin
      coll_cnt_r <= coll_cnt_r + CNT_WIDTH'(1);
    end
  end

  assign dout_r    = dout_data_r;
  assign dout_vld  = dout_vld_r;
  assign init_busy = init_busy_r;
  assign coll_cnt  = coll_cnt_r;

endmodule

// File: tb/tb_sram_2prf_v2.sv
// Scoreboard bench for sram_2prf_v2: three instances cover the default
// configuration, the output-register variant and a no-init / partial space one.
module tb_sram_2prf_v2;

  typedef struct {
    int         d;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      [3];
  logic [9:0] addr_w   [3];
  logic [7:0] din_w    [3];
  logic [7:0] wmask_n  [3];
  logic       ce_w     [3];
  logic       en_w     [3];
  logic [9:0] addr_r   [3];
  logic       ce_r     [3];
  logic       en_r     [3];
  logic [7:0] dout_r   [3];
  logic       dout_vld [3];
  logic       init_busy[3];
  logic [15:0] coll_cnt[3];

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // u0: defaults (latency 1, init sweep, 1024 words)
  sram_2prf_v2 u0 (
    .clk(clk), .rst(rst[0]), .addr_w(addr_w[0]), .din_w(din_w[0]), .wmask_n(wmask_n[0]),
    .ce_w(ce_w[0]), .en_w(en_w[0]), .addr_r(addr_r[0]), .ce_r(ce_r[0]), .en_r(en_r[0]),
    .dout_r(dout_r[0]), .dout_vld(dout_vld[0]), .init_busy(init_busy[0]), .coll_cnt(coll_cnt[0]));

  // u1: output register, 16 words filling a 4-bit address space
  sram_2prf_v2 #(.ADDR_WIDTH(4), .ADDR_SPACE(16), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst[1]), .addr_w(addr_w[1][3:0]), .din_w(din_w[1]), .wmask_n(wmask_n[1]),
    .ce_w(ce_w[1]), .en_w(en_w[1]), .addr_r(addr_r[1][3:0]), .ce_r(ce_r[1]), .en_r(en_r[1]),
    .dout_r(dout_r[1]), .dout_vld(dout_vld[1]), .init_busy(init_busy[1]), .coll_cnt(coll_cnt[1]));

  // u2: no init sweep, only 1000 of 1024 addresses populated
  sram_2prf_v2 #(.ADDR_SPACE(1000), .INIT_ON_RST(0)) u2 (
    .clk(clk), .rst(rst[2]), .addr_w(addr_w[2]), .din_w(din_w[2]), .wmask_n(wmask_n[2]),
    .ce_w(ce_w[2]), .en_w(en_w[2]), .addr_r(addr_r[2]), .ce_r(ce_r[2]), .en_r(en_r[2]),
    .dout_r(dout_r[2]), .dout_vld(dout_vld[2]), .init_busy(init_busy[2]), .coll_cnt(coll_cnt[2]));

  // Monitor: every valid pops the scoreboard and checks owner, data and cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (dout_vld[d] === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_vld u%0d: got dout_vld=1 data=%02h at cyc %0d, wanted no valid", d, dout_r[d], cyc);
        end else begin
          e = sb.pop_front();
          if (e.d != d || dout_r[d] !== e.data || cyc != e.cyc) begin
            n_err++;
            $display("FAIL read u%0d: got data=%02h cyc=%0d, wanted u%0d data=%02h cyc=%0d",
                     d, dout_r[d], cyc, e.d, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", name, got, want);
    end
  endtask

  task automatic set_idle(input int d);
    ce_w[d] = 1'b1; en_w[d] = 1'b1; ce_r[d] = 1'b1; en_r[d] = 1'b1;
    addr_w[d] = 10'd0; din_w[d] = 8'h00; wmask_n[d] = 8'hFF; addr_r[d] = 10'd0;
  endtask

  // One cycle of stimulus on instance d; a read pushes its expected result.
  task automatic step(input int d, input bit w, input logic [9:0] aw, input logic [7:0] dw,
                      input logic [7:0] m, input bit r, input logic [9:0] ar, input logic [7:0] ex);
    exp_t e;
    @(negedge clk);
    ce_w[d] = ~w; en_w[d] = ~w; addr_w[d] = aw; din_w[d] = dw; wmask_n[d] = m;
    ce_r[d] = ~r; en_r[d] = ~r; addr_r[d] = ar;
    if (r) begin
      e.d = d; e.data = ex; e.cyc = cyc + 1 + ((d == 1) ? 1 : 0);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b0, 10'd0, 8'h00);
  endtask

  // Pulse reset (optionally with user requests held) and measure the busy window.
  task automatic reset_and_sweep(input int d, input int want_busy, input bit hold, input string name);
    int busy = 0;
    int vld_seen = 0;
    @(negedge clk);
    rst[d] = 1'b1;
    if (hold) begin
      ce_r[d] = 1'b0; en_r[d] = 1'b0; addr_r[d] = 10'd1;
      ce_w[d] = 1'b0; en_w[d] = 1'b0; addr_w[d] = 10'd1; din_w[d] = 8'hAA; wmask_n[d] = 8'h00;
    end else begin
      set_idle(d);
    end
    @(negedge clk);
    rst[d] = 1'b0;
    check({name, "_dout_after_rst"}, {24'd0, dout_r[d]}, 32'd0);
    check({name, "_coll_after_rst"}, {16'd0, coll_cnt[d]}, 32'd0);
    check({name, "_vld_after_rst"}, {31'd0, dout_vld[d]}, 32'd0);
    while (init_busy[d] === 1'b1 && busy < 5000) begin
      busy++;
      if (dout_vld[d] === 1'b1) vld_seen++;
      @(negedge clk);
    end
    set_idle(d);
    check({name, "_busy_cycles"}, busy, want_busy);
    check({name, "_vld_during_init"}, vld_seen, 32'd0);
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by %0t, wanted completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      set_idle(d);
    end
    repeat (2) @(negedge clk);

    // Power-on sweeps
    reset_and_sweep(1, 16, 1'b0, "u1_por");
    reset_and_sweep(2, 0, 1'b0, "u2_por");
    reset_and_sweep(0, 1024, 1'b1, "u0_por");

    // u0: swept contents, including the write attempted during INIT
    step(0, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b1, 10'd0,    8'h00);
    step(0, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b1, 10'd512,  8'h00);
    step(0, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b1, 10'd1023, 8'h00);
    step(0, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b1, 10'd1,    8'h00);

    // u0: masked write then read, and hold after the read
    step(0, 1'b1, 10'd5, 8'hFF, 8'h00, 1'b0, 10'd0, 8'h00);
    step(0, 1'b1, 10'd5, 8'h00, 8'hF0, 1'b0, 10'd0, 8'h00);
    step(0, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b1, 10'd5, 8'hF0);
    idle(0, 3);
    check("u0_hold_data", {24'd0, dout_r[0]}, 32'hF0);
    check("u0_hold_vld", {31'd0, dout_vld[0]}, 32'd0);

    // u0: write-first collision
    step(0, 1'b1, 10'd7, 8'h12, 8'h00, 1'b0, 10'd0, 8'h00);
    step(0, 1'b1, 10'd7, 8'hAB, 8'h0F, 1'b1, 10'd7, 8'hA2);
    idle(0, 1);
    check("u0_coll_cnt_1", {16'd0, coll_cnt[0]}, 32'd1);

    // u0: simultaneous write/read to different addresses returns old data
    step(0, 1'b1, 10'd8, 8'h55, 8'h00, 1'b1, 10'd5, 8'hF0);
    step(0, 1'b1, 10'd9, 8'h11, 8'h00, 1'b1, 10'd8, 8'h55);
    idle(0, 1);
    check("u0_coll_cnt_diff_addr", {16'd0, coll_cnt[0]}, 32'd1);

    // u0: counter saturation
    for (int i = 0; i < 65540; i++) step(0, 1'b1, 10'd7, 8'hAB, 8'h0F, 1'b1, 10'd7, 8'hA2);
    idle(0, 2);
    check("u0_coll_cnt_sat", {16'd0, coll_cnt[0]}, 32'hFFFF);

    // u0: reset after activity re-sweeps the array
    reset_and_sweep(0, 1024, 1'b1, "u0_rst_after_sat");
    step(0, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b1, 10'd5, 8'h00);
    step(0, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b1, 10'd7, 8'h00);
    idle(0, 2);

    // u0: reset in the middle of a sweep restarts it
    @(negedge clk); rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    repeat (299) @(negedge clk);
    check("u0_busy_mid_sweep", {31'd0, init_busy[0]}, 32'd1);
    reset_and_sweep(0, 1024, 1'b1, "u0_sweep_restart");

    // u1: streaming reads with the output register
    for (int a = 0; a < 10; a++) step(1, 1'b1, 10'(a), 8'(a), 8'h00, 1'b0, 10'd0, 8'h00);
    for (int a = 0; a < 10; a++) step(1, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b1, 10'(a), 8'(a));
    idle(1, 3);
    check("u1_hold_data", {24'd0, dout_r[1]}, 32'd9);

    // u1: reset while a read is in the pipeline
    step(1, 1'b1, 10'd12, 8'hC3, 8'h00, 1'b0, 10'd0, 8'h00);
    @(negedge clk);
    ce_w[1] = 1'b1; en_w[1] = 1'b1;
    ce_r[1] = 1'b0; en_r[1] = 1'b0; addr_r[1] = 10'd12;
    reset_and_sweep(1, 16, 1'b1, "u1_mid_read");
    step(1, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b1, 10'd12, 8'h00);
    step(1, 1'b0, 10'd0, 8'h00, 8'hFF, 1'b1, 10'd1,  8'h00);
    idle(1, 3);

    // u2: contents survive reset without a sweep; out-of-range accesses
    step(2, 1'b1, 10'd10,  8'h3C, 8'h00, 1'b0, 10'd0, 8'h00);
    step(2, 1'b1, 10'd999, 8'h99, 8'h00, 1'b0, 10'd0, 8'h00);
    step(2, 1'b1, 10'd23,  8'h23, 8'h00, 1'b0, 10'd0, 8'h00);
    reset_and_sweep(2, 0, 1'b0, "u2_rst");
    step(2, 1'b0, 10'd0,    8'h00, 8'hFF, 1'b1, 10'd10,   8'h3C);
    step(2, 1'b0, 10'd0,    8'h00, 8'hFF, 1'b1, 10'd999,  8'h99);
    step(2, 1'b1, 10'd1023, 8'hEE, 8'h00, 1'b1, 10'd1010, 8'h00);
    step(2, 1'b1, 10'd1010, 8'hEE, 8'h00, 1'b1, 10'd1010, 8'h00);
    step(2, 1'b0, 10'd0,    8'h00, 8'hFF, 1'b1, 10'd1023, 8'h00);
    step(2, 1'b0, 10'd0,    8'h00, 8'hFF, 1'b1, 10'd23,   8'h23);
    step(2, 1'b0, 10'd0,    8'h00, 8'hFF, 1'b1, 10'd999,  8'h99);
    idle(2, 3);
    check("u2_coll_out_of_range", {16'd0, coll_cnt[2]}, 32'd0);

    idle(0, 5);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
